// File: rtl/clock_monitor.sv
// Counts rising edges of an asynchronous signal over back-to-back windows of
// WINDOW clk_in cycles and reports the count with in-range / stuck flags.
module clock_monitor #(
  parameter int WINDOW  = 1024,
  parameter int CNT_W   = 16,
  parameter int EXP_MIN = 511,
  parameter int EXP_MAX = 513
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             in_range,
  output logic             stuck
);

  localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             rise;
  logic [WIN_W-1:0] win_cnt, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_d, edge_sum;
  logic [CNT_W-1:0] count_d;
  logic             valid_d, in_range_d, stuck_d;

  // The first enabled cycle is already window cycle 0, so the state follows
  // enable directly rather than lagging it by a register stage.
  assign state = enable ? MEASURE : IDLE;

  // Synchronizer and history flop run regardless of enable so that a signal
  // already high when enable rises is not mistaken for an edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let s1->s2->s3 shift as a true pipeline;
      // blocking ones would collapse the chain into a single flop.
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign edge_sum = (rise && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    win_cnt_d  = '0;
    edge_cnt_d = '0;
    valid_d    = 1'b0;
    count_d    = count;
    in_range_d = in_range;
    stuck_d    = stuck;
    unique case (state)
      IDLE: begin
      end
      MEASURE: begin
        if (win_cnt == WIN_LAST) begin
          count_d    = edge_sum;
          in_range_d = (int'(edge_sum) >= EXP_MIN) && (int'(edge_sum) <= EXP_MAX);
          stuck_d    = (edge_sum == '0);
          valid_d    = 1'b1;
        end else begin
          win_cnt_d  = win_cnt + WIN_W'(1);
          edge_cnt_d = edge_sum;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      count    <= '0;
      valid    <= 1'b0;
      in_range <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      win_cnt  <= win_cnt_d;
      edge_cnt <= edge_cnt_d;
      count    <= count_d;
      valid    <= valid_d;
      in_range <= in_range_d;
      stuck    <= stuck_d;
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Randomized self-checking bench for clock_monitor: a history-based model
// counts rising edges of the driven signal per window and predicts each report.
`timescale 1ns/1ps
module tb_clock_monitor;

  localparam int WINDOW    = 1024;
  localparam int CNT_W     = 16;
  localparam int EXP_MIN   = 511;
  localparam int EXP_MAX   = 513;
  localparam int S_WINDOW  = 64;
  localparam int S_CNT_W   = 4;
  localparam int S_EXP_MIN = 10;
  localparam int S_EXP_MAX = 15;
  localparam int HIST      = 32768;

  typedef enum logic [2:0] {SIG_ZERO, SIG_ONE, SIG_DIV2, SIG_DIV4, SIG_RAND} sig_mode_t;

  logic               clk_in = 1'b0;
  logic               reset  = 1'b1;
  logic               sig_in = 1'b0;
  logic               enable = 1'b0;
  logic [CNT_W-1:0]   count;
  logic               valid, in_range, stuck;
  logic [S_CNT_W-1:0] s_count;
  logic               s_valid, s_in_range, s_stuck;

  clock_monitor #(.WINDOW(WINDOW), .CNT_W(CNT_W), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX)) dut (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .enable(enable),
    .count(count), .valid(valid), .in_range(in_range), .stuck(stuck)
  );

  clock_monitor #(.WINDOW(S_WINDOW), .CNT_W(S_CNT_W), .EXP_MIN(S_EXP_MIN), .EXP_MAX(S_EXP_MAX)) dut_sat (
    .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .enable(enable),
    .count(s_count), .valid(s_valid), .in_range(s_in_range), .stuck(s_stuck)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int win_start = -1;
  bit hist [HIST];

  logic               exp_valid = 1'b0, exp_in_range = 1'b0, exp_stuck = 1'b0;
  logic [CNT_W-1:0]   exp_count = '0;
  logic               s_exp_valid = 1'b0, s_exp_in_range = 1'b0, s_exp_stuck = 1'b0;
  logic [S_CNT_W-1:0] s_exp_count = '0;

  // A rise driven in cycle m reaches the counter two cycles later, so the
  // window reported at cycle c covers rises driven in [c-w-2, c-3].
  function automatic int rises_before(int c, int w);
    int n = 0;
    for (int m = c - w - 2; m <= c - 3; m++)
      if (m >= 1 && hist[m] && !hist[m-1]) n++;
    return n;
  endfunction

  function automatic string obs();
    return $sformatf("%b/%0d/%b/%b", valid, count, in_range, stuck);
  endfunction

  function automatic string expd();
    return $sformatf("%b/%0d/%b/%b", exp_valid, exp_count, exp_in_range, exp_stuck);
  endfunction

  function automatic string s_obs();
    return $sformatf("%b/%0d/%b/%b", s_valid, s_count, s_in_range, s_stuck);
  endfunction

  function automatic string s_expd();
    return $sformatf("%b/%0d/%b/%b", s_exp_valid, s_exp_count, s_exp_in_range, s_exp_stuck);
  endfunction

  // Advance one cycle, drive this cycle's inputs and update the model's view of
  // what the outputs should be during this cycle.
  task automatic tick(input bit en, input sig_mode_t mode, input bit rst_v);
    bit v;
    int n, sat;
    @(posedge clk_in);
    #1;
    cyc++;
    if (cyc >= HIST) begin
      failures++;
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HIST);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "cycle budget exhausted");
    end
    exp_valid   = 1'b0;
    s_exp_valid = 1'b0;
    if (win_start >= 0 && cyc > win_start) begin
      if ((cyc - win_start) % WINDOW == 0) begin
        n   = rises_before(cyc, WINDOW);
        sat = (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
        exp_valid    = 1'b1;
        exp_count    = CNT_W'(sat);
        exp_in_range = (sat >= EXP_MIN) && (sat <= EXP_MAX);
        exp_stuck    = (sat == 0);
      end
      if ((cyc - win_start) % S_WINDOW == 0) begin
        n   = rises_before(cyc, S_WINDOW);
        sat = (n > (1 << S_CNT_W) - 1) ? (1 << S_CNT_W) - 1 : n;
        s_exp_valid    = 1'b1;
        s_exp_count    = S_CNT_W'(sat);
        s_exp_in_range = (sat >= S_EXP_MIN) && (sat <= S_EXP_MAX);
        s_exp_stuck    = (sat == 0);
      end
    end
    case (mode)
      SIG_ZERO: v = 1'b0;
      SIG_ONE:  v = 1'b1;
      SIG_DIV2: v = (cyc % 2) != 0;
      SIG_DIV4: v = ((cyc / 2) % 2) != 0;
      default:  v = 1'($urandom_range(0, 1));
    endcase
    sig_in = v;
    enable = en;
    reset  = rst_v;
    if (rst_v) begin
      exp_valid = 1'b0; exp_count = '0; exp_in_range = 1'b0; exp_stuck = 1'b0;
      s_exp_valid = 1'b0; s_exp_count = '0; s_exp_in_range = 1'b0; s_exp_stuck = 1'b0;
    end
    hist[cyc] = v && !rst_v;
    if (rst_v || !en) win_start = -1;
    else if (win_start < 0) win_start = cyc;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, SIG_ZERO, 1'b1);
      checks++;
      if ({valid, count, in_range, stuck} !== '0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%s required=0/0/0/0", cyc, obs());
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, SIG_ZERO, 1'b0);
      checks++;
      if (valid !== exp_valid || count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%s required=%s", cyc, obs(), expd());
      end
    end
  endtask

  task automatic test_div2();
    int pulses = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, SIG_DIV2, 1'b0);
    for (int i = 0; i < 3 * WINDOW + 4; i++) begin
      tick(1'b1, SIG_DIV2, 1'b0);
      checks++;
      if (valid !== exp_valid || count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck) begin
        failures++;
        $display("FAIL div2 cyc=%0d got=%s required=%s", cyc, obs(), expd());
      end
      if (valid === 1'b1 && count === 16'd512 && in_range === 1'b1 && stuck === 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL div2_pulses got=%0d required=3", pulses);
    end
  endtask

  task automatic test_constant();
    int pulses = 0;
    sig_mode_t modes [2] = '{SIG_ZERO, SIG_ONE};
    foreach (modes[k]) begin
      for (int i = 0; i < 6; i++) tick(1'b0, modes[k], 1'b0);
      for (int i = 0; i < WINDOW + 2; i++) begin
        tick(1'b1, modes[k], 1'b0);
        checks++;
        if (valid !== exp_valid || count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck) begin
          failures++;
          $display("FAIL constant cyc=%0d got=%s required=%s", cyc, obs(), expd());
        end
        if (valid === 1'b1 && count === 16'd0 && in_range === 1'b0 && stuck === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL constant_pulses got=%0d required=2", pulses);
    end
  endtask

  task automatic test_div4();
    int pulses = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, SIG_DIV4, 1'b0);
    for (int i = 0; i < 2 * WINDOW + 2; i++) begin
      tick(1'b1, SIG_DIV4, 1'b0);
      checks++;
      if (valid !== exp_valid || count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck) begin
        failures++;
        $display("FAIL div4 cyc=%0d got=%s required=%s", cyc, obs(), expd());
      end
      if (valid === 1'b1 && count === 16'd256 && in_range === 1'b0 && stuck === 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL div4_pulses got=%0d required=2", pulses);
    end
  endtask

  task automatic test_enable_drop();
    int reen_cyc = 0, pulse_cyc = 0, pulses = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, SIG_DIV2, 1'b0);
    for (int i = 0; i < WINDOW + 500 + 20 + WINDOW + 2; i++) begin
      bit en = !(i >= WINDOW + 500 && i < WINDOW + 520);
      tick(en, SIG_DIV2, 1'b0);
      if (i == WINDOW + 520) reen_cyc = cyc;
      checks++;
      if (valid !== exp_valid || count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck) begin
        failures++;
        $display("FAIL enable_drop cyc=%0d got=%s required=%s", cyc, obs(), expd());
      end
      if (valid === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
      end
    end
    checks++;
    if (pulses !== 2 || pulse_cyc - reen_cyc !== WINDOW || count !== 16'd512) begin
      failures++;
      $display("FAIL enable_drop_timing pulses=%0d gap=%0d count=%0d required pulses=2 gap=%0d count=512",
               pulses, pulse_cyc - reen_cyc, count, WINDOW);
    end
  endtask

  task automatic test_reset_mid();
    int rel_cyc = 0, pulse_cyc = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, SIG_DIV2, 1'b0);
    for (int i = 0; i < WINDOW + 700; i++) tick(1'b1, SIG_DIV2, 1'b0);
    checks++;
    if (count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck || count !== 16'd512) begin
      failures++;
      $display("FAIL reset_mid_before got=%s required=%s", obs(), expd());
    end
    tick(1'b1, SIG_DIV2, 1'b1);
    checks++;
    if ({valid, count, in_range, stuck} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%s required=0/0/0/0", obs());
    end
    for (int i = 0; i < 2; i++) tick(1'b1, SIG_DIV2, 1'b1);
    for (int i = 0; i < WINDOW + 2; i++) begin
      tick(1'b1, SIG_DIV2, 1'b0);
      if (i == 0) rel_cyc = cyc;
      checks++;
      if (valid !== exp_valid || count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%s required=%s", cyc, obs(), expd());
      end
      if (valid === 1'b1) pulse_cyc = cyc;
    end
    checks++;
    if (pulse_cyc - rel_cyc !== WINDOW) begin
      failures++;
      $display("FAIL reset_mid_first_report gap=%0d required=%0d", pulse_cyc - rel_cyc, WINDOW);
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, SIG_DIV2, 1'b0);
    for (int i = 0; i < 3 * S_WINDOW + 2; i++) begin
      tick(1'b1, SIG_DIV2, 1'b0);
      checks++;
      if (s_valid !== s_exp_valid || s_count !== s_exp_count || s_in_range !== s_exp_in_range || s_stuck !== s_exp_stuck) begin
        failures++;
        $display("FAIL saturation cyc=%0d got=%s required=%s", cyc, s_obs(), s_expd());
      end
      if (s_valid === 1'b1 && s_count === 4'd15) pulses++;
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL saturation_pulses got=%0d required=3", pulses);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 3; seg++) begin
      sig_mode_t mode = sig_mode_t'($urandom_range(0, 4));
      int len = $urandom_range(200, 2100);
      int gap = $urandom_range(1, 5);
      for (int i = 0; i < len + gap; i++) begin
        tick(i < len, (seg == 2) ? SIG_RAND : mode, 1'b0);
        checks++;
        if (valid !== exp_valid || count !== exp_count || in_range !== exp_in_range || stuck !== exp_stuck) begin
          failures++;
          $display("FAIL random cyc=%0d got=%s required=%s", cyc, obs(), expd());
        end
        checks++;
        if (s_valid !== s_exp_valid || s_count !== s_exp_count || s_in_range !== s_exp_in_range || s_stuck !== s_exp_stuck) begin
          failures++;
          $display("FAIL random_sat cyc=%0d got=%s required=%s", cyc, s_obs(), s_expd());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_constant();
    test_div4();
    test_enable_drop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
